// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 MAC sequencer.
// Holds the sequencer state encoding, OPMODE words and the tag latency helper.
package dsp_seq_pkg;

   typedef enum logic [2:0] {
      RST_FLUSH,
      IDLE,
      STREAM,
      DRAIN,
      HOLD
   } state_t;

   // X=M, Z=0 clears the accumulator; X=M, Z=P accumulates onto it.
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;

   // Edges from operand registration at the slice pins until P holds the sum.
   function automatic int calc_tag_lat(input int ab_lat, input int m_lat, input int p_lat);
      return ab_lat + m_lat + p_lat;
   endfunction

endpackage

// File: rtl/dsp_seq_tag_pipe.sv
// Parameterised-depth shift register carrying sequencer tags (opmode or last flag)
// alongside operands as they travel through the slice.
module dsp_seq_tag_pipe #(
   parameter int W     = 1,
   parameter int DEPTH = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         assign q = d;
      end else begin : g_shift
         logic [W-1:0] stages [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
            end else begin
               stages[0] <= d;
               for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
         end

         assign q = stages[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1-style slice to compute signed dot products of streamed (A,B) pairs.
// Define DSPSEQ_SAT_EN to saturate the captured P to RES_W bits and add the res_sat output.
module dsp_mac_sequencer
   import dsp_seq_pkg::*;
#(
   parameter int LEN_W   = 10,
   parameter int AB_LAT  = 1,
   parameter int M_LAT   = 1,
   parameter int P_LAT   = 1,
   parameter int OPM_LAT = 1,
   parameter int RES_W   = 32
) (
   input  logic               clk,
   input  logic               RST_N,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic signed [17:0] s_a,
   input  logic signed [17:0] s_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [RES_W-1:0]   res_data,
   output logic [17:0]        dsp_a,
   output logic [17:0]        dsp_b,
   output logic [7:0]         dsp_opmode,
   output logic               dsp_ce,
   output logic               dsp_rst,
   input  logic [47:0]        dsp_p
`ifdef DSPSEQ_SAT_EN
   ,
   output logic               res_sat
`endif
);

   localparam int TAG_LAT = calc_tag_lat(AB_LAT, M_LAT, P_LAT);
   localparam int OPM_DLY = AB_LAT + M_LAT - OPM_LAT;

   state_t           state;
   logic [LEN_W-1:0] count;
   logic             first_pend;
   logic [7:0]       opm_tag;
   logic             last_tag;
   logic             last_out;
   logic [RES_W-1:0] p_clip;
   logic             p_sat;

   // Tags are registered in step with dsp_a/dsp_b, then delayed to meet their product.
   dsp_seq_tag_pipe #(.W(8), .DEPTH(OPM_DLY)) u_opm_pipe (
      .clk   (clk),
      .rst_n (RST_N),
      .d     (opm_tag),
      .q     (dsp_opmode)
   );

   dsp_seq_tag_pipe #(.W(1), .DEPTH(TAG_LAT)) u_last_pipe (
      .clk   (clk),
      .rst_n (RST_N),
      .d     (last_tag),
      .q     (last_out)
   );

`ifdef DSPSEQ_SAT_EN
   localparam logic signed [47:0] RES_MAX = (48'sd1 <<< (RES_W-1)) - 48'sd1;
   localparam logic signed [47:0] RES_MIN = -(48'sd1 <<< (RES_W-1));

   always_comb begin
      p_clip = dsp_p[RES_W-1:0];
      p_sat  = 1'b0;
      if ($signed(dsp_p) > RES_MAX) begin
         p_clip = RES_MAX[RES_W-1:0];
         p_sat  = 1'b1;
      end else if ($signed(dsp_p) < RES_MIN) begin
         p_clip = RES_MIN[RES_W-1:0];
         p_sat  = 1'b1;
      end
   end
`else
   logic unused_p_hi;
   assign unused_p_hi = ^dsp_p;
   assign p_clip      = dsp_p[RES_W-1:0];
   assign p_sat       = 1'b0;
`endif

   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state      <= RST_FLUSH;
         cmd_ready  <= 1'b0;
         s_ready    <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         dsp_a      <= '0;
         dsp_b      <= '0;
         dsp_ce     <= 1'b0;
         dsp_rst    <= 1'b1;
         count      <= '0;
         first_pend <= 1'b0;
         opm_tag    <= '0;
         last_tag   <= 1'b0;
`ifdef DSPSEQ_SAT_EN
         res_sat    <= 1'b0;
`endif
      end else begin
         // Idle slots feed a zero product with accumulate, leaving P untouched.
         dsp_a    <= '0;
         dsp_b    <= '0;
         opm_tag  <= OPM_ACC;
         last_tag <= 1'b0;

         case (state)
            RST_FLUSH: begin
               if (!dsp_ce) begin
                  dsp_ce <= 1'b1;
               end else begin
                  dsp_rst   <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (cmd_len == '0) begin
                     res_data  <= '0;
                     res_valid <= 1'b1;
`ifdef DSPSEQ_SAT_EN
                     res_sat   <= 1'b0;
`endif
                     state     <= HOLD;
                  end else begin
                     count      <= cmd_len;
                     first_pend <= 1'b1;
                     s_ready    <= 1'b1;
                     state      <= STREAM;
                  end
               end
            end

            STREAM: begin
               if (s_valid && s_ready) begin
                  dsp_a      <= s_a;
                  dsp_b      <= s_b;
                  opm_tag    <= first_pend ? OPM_FIRST : OPM_ACC;
                  first_pend <= 1'b0;
                  last_tag   <= (count == LEN_W'(1));
                  count      <= count - LEN_W'(1);
                  if (count == LEN_W'(1)) begin
                     s_ready <= 1'b0;
                     state   <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (last_out) begin
                  res_data  <= p_clip;
                  res_valid <= 1'b1;
`ifdef DSPSEQ_SAT_EN
                  res_sat   <= p_sat;
`endif
                  state     <= HOLD;
               end
            end

            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               cmd_ready <= 1'b0;
               s_ready   <= 1'b0;
               res_valid <= 1'b0;
               dsp_ce    <= 1'b0;
               dsp_rst   <= 1'b1;
               state     <= RST_FLUSH;
            end
         endcase
      end
   end

`ifndef DSPSEQ_SAT_EN
   logic unused_sat;
   assign unused_sat = p_sat;
`endif

endmodule
